// File: rtl/axis_adc_decimator_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_adc_decimator_v2: decimating ADC-to-AXI4-Stream packer, sign-extends |
// | lanes; optional framing (tlast) via macro ADC_TLAST_EN.  Rev 2.0         |
// +--------------------------------------------------------------------------+
module axis_adc_decimator_v2 #(
  parameter int N_CH    = 2,
  parameter int ADC_W   = 14,
  parameter int LANE_W  = 16,
  parameter int PRESC_W = 32,
  parameter int FRAME_W = 16
) (
  input  logic                     aclk,
  input  logic                     rstn,
  input  logic                     i_sample_valid,
  input  logic [N_CH*ADC_W-1:0]    i_data,
  input  logic                     i_enable,
  input  logic [PRESC_W-1:0]       i_prescaler,
  input  logic [FRAME_W-1:0]       i_frame_len,
  input  logic                     i_clear_ovf,
  input  logic                     axis_tready,
  output logic                     axis_tvalid,
  output logic [N_CH*LANE_W-1:0]   axis_tdata,
  output logic                     axis_tlast,
  output logic [15:0]              o_overflow_count
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
  localparam logic [15:0]        OVF_MAX   = 16'hFFFF;

  logic [PRESC_W-1:0]     smp_cnt;
  logic [N_CH*LANE_W-1:0] lanes;
  logic                   capture;
  logic                   handshake;
  logic                   load;
  logic                   drop;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    assign lanes[k*LANE_W +: LANE_W] = LANE_W'($signed(i_data[k*ADC_W +: ADC_W]));
  end

  assign capture   = i_sample_valid && i_enable && (smp_cnt >= i_prescaler);
  assign handshake = axis_tvalid && axis_tready;
  assign load      = capture && (!axis_tvalid || handshake);
  assign drop      = capture && !load;

  // Decimation counter free-runs on strobes; it never waits for tready.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      smp_cnt <= '0;
    end else if (!i_enable) begin
      smp_cnt <= '0;
    end else if (i_sample_valid) begin
      smp_cnt <= capture ? '0 : smp_cnt + PRESC_ONE;
    end
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
    end else if (load) begin
      axis_tvalid <= 1'b1;
      axis_tdata  <= lanes;
    end else if (handshake) begin
      axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      o_overflow_count <= '0;
    end else if (i_clear_ovf) begin
      o_overflow_count <= '0;
    end else if (drop && (o_overflow_count != OVF_MAX)) begin
      o_overflow_count <= o_overflow_count + 16'd1;
    end
  end

`ifdef ADC_TLAST_EN
  localparam logic [FRAME_W:0]   FRAME_ONE = 1;
  localparam logic [FRAME_W-1:0] BEAT_ONE  = 1;

  logic [FRAME_W-1:0] beats_done;
  logic [FRAME_W-1:0] done_next;
  logic [FRAME_W-1:0] frame_eff;

  assign frame_eff = (i_frame_len == '0) ? BEAT_ONE : i_frame_len;
  // Beats already accepted in the current frame, including this cycle's handshake.
  assign done_next = handshake ? (axis_tlast ? '0 : beats_done + BEAT_ONE) : beats_done;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      beats_done <= '0;
      axis_tlast <= 1'b0;
    end else begin
      beats_done <= done_next;
      if (load) begin
        axis_tlast <= (({1'b0, done_next} + FRAME_ONE) >= {1'b0, frame_eff});
      end
    end
  end
`else
  logic unused_frame_len;
  assign unused_frame_len = ^i_frame_len;
  assign axis_tlast       = 1'b0;
`endif

endmodule
`default_nettype wire
